// File: rtl/apb_rr_arbiter_if.sv
// Bus bundle for the APB round-robin arbiter: N upstream completer ports,
// one downstream requester port and the one-hot grant vector.
interface apb_rr_arbiter_if #(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // upstream requesters, packed with master i in slice i
  logic [N_MASTERS-1:0]            S_PSEL;
  logic [N_MASTERS-1:0]            S_PENABLE;
  logic [N_MASTERS-1:0]            S_PWRITE;
  logic [N_MASTERS*ADDR_WIDTH-1:0] S_PADDR;
  logic [N_MASTERS*DATA_WIDTH-1:0] S_PWDATA;
  logic [N_MASTERS*STRB_WIDTH-1:0] S_PSTRB;
  logic [N_MASTERS*3-1:0]          S_PPROT;
  logic [N_MASTERS-1:0]            S_PREADY;
  logic [N_MASTERS*DATA_WIDTH-1:0] S_PRDATA;
  logic [N_MASTERS-1:0]            S_PSLVERR;

  // downstream completer
  logic                  M_PSEL;
  logic                  M_PENABLE;
  logic                  M_PWRITE;
  logic [ADDR_WIDTH-1:0] M_PADDR;
  logic [DATA_WIDTH-1:0] M_PWDATA;
  logic [STRB_WIDTH-1:0] M_PSTRB;
  logic [2:0]            M_PPROT;
  logic                  M_PREADY;
  logic [DATA_WIDTH-1:0] M_PRDATA;
  logic                  M_PSLVERR;

  logic [N_MASTERS-1:0]  GNT;

  // arbiter side
  modport slave (
    input  S_PSEL, S_PENABLE, S_PWRITE, S_PADDR, S_PWDATA, S_PSTRB, S_PPROT,
    output S_PREADY, S_PRDATA, S_PSLVERR,
    output M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA, M_PSTRB, M_PPROT,
    input  M_PREADY, M_PRDATA, M_PSLVERR,
    output GNT
  );

  // environment side: upstream masters plus the downstream slave
  modport master (
    output S_PSEL, S_PENABLE, S_PWRITE, S_PADDR, S_PWDATA, S_PSTRB, S_PPROT,
    input  S_PREADY, S_PRDATA, S_PSLVERR,
    input  M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA, M_PSTRB, M_PPROT,
    output M_PREADY, M_PRDATA, M_PSLVERR,
    input  GNT
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter serialising N upstream APB requesters onto one registered
// downstream APB port, with an optional ACCESS-phase timeout that answers PSLVERR.
module apb_rr_arbiter #(
  parameter int N_MASTERS      = 2,
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            PCLK,
  input  logic            PRESET,
  apb_rr_arbiter_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = $clog2(N_MASTERS);
  localparam int CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(N_MASTERS - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      last_grant_reg, last_grant_next;
  logic [IDX_W-1:0]      grant_idx_reg, grant_idx_next;
  logic [N_MASTERS-1:0]  gnt_reg, gnt_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  pwrite_reg, pwrite_next;
  logic [ADDR_WIDTH-1:0] paddr_reg, paddr_next;
  logic [DATA_WIDTH-1:0] pwdata_reg, pwdata_next;
  logic [STRB_WIDTH-1:0] pstrb_reg, pstrb_next;
  logic [2:0]            pprot_reg, pprot_next;

  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W-1:0]      cand_idx;
  logic                  in_access;
  logic                  timeout_hit;
  logic                  xfer_done;
  logic                  unused_penable;

  assign unused_penable = ^bus.S_PENABLE;

  // Search starts just after the last served master, so it ends up lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int off = 1; off <= N_MASTERS; off++) begin
      cand_idx = IDX_W'((int'(last_grant_reg) + off) % N_MASTERS);
      if (!win_found && bus.S_PSEL[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // A ready slave in the last allowed cycle wins over the timeout.
  assign in_access   = (state_reg == ACCESS);
  assign timeout_hit = in_access && !bus.M_PREADY && (TIMEOUT_CYCLES != 0)
                       && (cnt_reg == CNT_W'(TO_LAST));
  assign xfer_done   = in_access && (bus.M_PREADY || timeout_hit);

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_idx_next  = grant_idx_reg;
    gnt_next        = gnt_reg;
    cnt_next        = cnt_reg;
    pwrite_next     = pwrite_reg;
    paddr_next      = paddr_reg;
    pwdata_next     = pwdata_reg;
    pstrb_next      = pstrb_reg;
    pprot_next      = pprot_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next     = SETUP;
          grant_idx_next = win_idx;
          gnt_next       = N_MASTERS'(1) << win_idx;
          pwrite_next    = bus.S_PWRITE[win_idx];
          paddr_next     = bus.S_PADDR[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          pwdata_next    = bus.S_PWDATA[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          pstrb_next     = bus.S_PSTRB[int'(win_idx)*STRB_WIDTH +: STRB_WIDTH];
          pprot_next     = bus.S_PPROT[int'(win_idx)*3 +: 3];
        end
      end
      SETUP: begin
        state_next = ACCESS;
        cnt_next   = '0;
      end
      ACCESS: begin
        if (xfer_done) begin
          state_next      = IDLE;
          gnt_next        = '0;
          last_grant_next = grant_idx_reg;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_reg      <= IDLE;
      last_grant_reg <= LAST_RESET;
      grant_idx_reg  <= '0;
      gnt_reg        <= '0;
      cnt_reg        <= '0;
      pwrite_reg     <= 1'b0;
      paddr_reg      <= '0;
      pwdata_reg     <= '0;
      pstrb_reg      <= '0;
      pprot_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      grant_idx_reg  <= grant_idx_next;
      gnt_reg        <= gnt_next;
      cnt_reg        <= cnt_next;
      pwrite_reg     <= pwrite_next;
      paddr_reg      <= paddr_next;
      pwdata_reg     <= pwdata_next;
      pstrb_reg      <= pstrb_next;
      pprot_reg      <= pprot_next;
    end
  end

  assign bus.M_PSEL    = (state_reg != IDLE);
  assign bus.M_PENABLE = in_access;
  assign bus.M_PWRITE  = pwrite_reg;
  assign bus.M_PADDR   = paddr_reg;
  assign bus.M_PWDATA  = pwdata_reg;
  assign bus.M_PSTRB   = pstrb_reg;
  assign bus.M_PPROT   = pprot_reg;
  assign bus.GNT       = gnt_reg;

  logic [N_MASTERS-1:0]            resp_hit;
  logic [N_MASTERS-1:0]            pslverr_w;
  logic [N_MASTERS*DATA_WIDTH-1:0] prdata_w;

  // A master that dropped PSEL early has its response discarded.
  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_resp
      assign resp_hit[gi]  = xfer_done && gnt_reg[gi] && bus.S_PSEL[gi];
      assign pslverr_w[gi] = resp_hit[gi] && (timeout_hit || bus.M_PSLVERR);
      assign prdata_w[gi*DATA_WIDTH +: DATA_WIDTH] =
          (resp_hit[gi] && !timeout_hit) ? bus.M_PRDATA : '0;
    end
  endgenerate

  assign bus.S_PREADY  = resp_hit;
  assign bus.S_PSLVERR = pslverr_w;
  assign bus.S_PRDATA  = prdata_w;
endmodule

// File: doc/apb_rr_arbiter.md
# apb_rr_arbiter

Round-robin arbiter that shares one downstream APB bus (register slaves) between N_MASTERS upstream APB requesters, typically several axi_lite_2_apb bridge instances. Each upstream port looks like an APB completer; the arbiter serialises their transfers onto a single registered APB requester port. A programmable timeout turns a hung slave into a PSLVERR response.

## Interface
- N_MASTERS, 2, number of upstream APB ports (2..8)
- ADDR_WIDTH, 5, APB address width
- DATA_WIDTH, 32, APB data width; strobe width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; 0 disables the timeout
- PCLK  in  1  single clock for all ports
- PRESET  in  1  synchronous, active-high reset
- S_PSEL  in  N_MASTERS  per-master select
- S_PENABLE  in  N_MASTERS  per-master enable; ignored by the arbiter
- S_PWRITE  in  N_MASTERS  per-master direction
- S_PADDR  in  N_MASTERS*ADDR_WIDTH  packed addresses; master i in slice i
- S_PWDATA  in  N_MASTERS*DATA_WIDTH  packed write data
- S_PSTRB  in  N_MASTERS*DATA_WIDTH/8  packed strobes
- S_PPROT  in  N_MASTERS*3  packed protection bits
- S_PREADY  out  N_MASTERS  per-master completion
- S_PRDATA  out  N_MASTERS*DATA_WIDTH  packed read data
- S_PSLVERR  out  N_MASTERS  per-master error
- M_PSEL, M_PENABLE, M_PWRITE  out  1  downstream control
- M_PADDR  out  ADDR_WIDTH  downstream address
- M_PWDATA  out  DATA_WIDTH  downstream write data
- M_PSTRB  out  DATA_WIDTH/8  downstream strobes
- M_PPROT  out  3  downstream protection bits
- M_PREADY  in  1  downstream ready
- M_PRDATA  in  DATA_WIDTH  downstream read data
- M_PSLVERR  in  1  downstream error
- GNT  out  N_MASTERS  one-hot grant, 0 when IDLE

## Operation
- FSM: IDLE, SETUP, ACCESS.
- IDLE: if any S_PSEL[i] is high, pick the winner round-robin. Search starts at (last_grant+1) mod N_MASTERS. Register the winner's PADDR/PWRITE/PWDATA/PSTRB/PPROT into the M_* outputs. Set GNT and go to SETUP. If no S_PSEL is high, stay in IDLE.
- SETUP: M_PSEL=1, M_PENABLE=0. Go to ACCESS and clear the timeout counter.
- ACCESS: M_PSEL=1, M_PENABLE=1.
  - When M_PREADY=1, route the response combinationally to the granted master: S_PREADY[g]=1, S_PRDATA slice g = M_PRDATA, S_PSLVERR[g]=M_PSLVERR.
  - Then go to IDLE, set last_grant=g and drop M_PSEL/M_PENABLE.
- Timeout: in ACCESS, the counter increments each cycle M_PREADY=0. When the count reaches TIMEOUT_CYCLES-1 with M_PREADY still 0:
  - Respond S_PREADY[g]=1, S_PSLVERR[g]=1, S_PRDATA slice g = 0.
  - Go to IDLE. The downstream slave is abandoned.
- Non-granted masters always see S_PREADY=0, S_PSLVERR=0 and S_PRDATA slice = 0.
- Upstream masters must hold their command stable while their S_PSEL is high.
- An upstream PSEL drop before completion is protocol-illegal. The arbiter still finishes the downstream transfer and discards the response.
- Round-robin: the most recently served master has the lowest priority on the next arbitration. After reset last_grant = N_MASTERS-1, so master 0 has the highest priority.

## Timing
- Reset (PRESET high at a PCLK edge):
  - state=IDLE, GNT=0, last_grant=N_MASTERS-1, counter=0.
  - All M_* outputs 0; all S_PREADY/S_PSLVERR/S_PRDATA 0.
- Reset mid-transfer drops M_PSEL at the same edge. The in-flight upstream master gets no response.
- Latency, request seen in IDLE at edge k:
  - M_PSEL=1 from k+1.
  - M_PENABLE=1 from k+2.
  - With a zero-wait slave, S_PREADY pulses during cycle k+2 and state=IDLE at k+3.
  - Minimum 3 cycles per transfer, with one IDLE cycle between transfers.
- Each wait state adds 1 cycle.
- Timeout response appears in ACCESS cycle number TIMEOUT_CYCLES, counting from the first ACCESS cycle.
- If M_PREADY=1 in the same cycle the timeout fires, it is a normal completion, not an error.
- S_PREADY is high for exactly one cycle per granted transfer.
- A simultaneous new request from the just-served master in the IDLE cycle loses to any other pending master.

## Test plan
- Single write, master 0: ADDR 0x04, DATA 0xDEADBEEF, STRB 0xF, zero-wait slave -> M_PSEL at +1, M_PENABLE at +2, M_PADDR=0x04, M_PWDATA=0xDEADBEEF, S_PREADY[0] one cycle at +2, GNT=01 then 00.
- Contention: both masters request reads at the same edge after reset; slave returns 0x11 for addr 0x00 and 0x22 for addr 0x08 -> master 0 served first and gets 0x11; master 1 served next and gets 0x22; S_PREADY[1] stays 0 until its own ACCESS.
- Fairness: master 0 issues 4 back-to-back writes while master 1 holds one request -> grant order 0,1,0,0,0; master 1 is never starved.
- Wait states: slave holds M_PREADY low for 5 ACCESS cycles, returns 0xCAFEF00D with M_PSLVERR=1 -> S_PRDATA=0xCAFEF00D and S_PSLVERR=1 for the granted master, on the 6th ACCESS cycle.
- Timeout, TIMEOUT_CYCLES=16: slave never asserts M_PREADY -> on ACCESS cycle 16, S_PREADY=1, S_PSLVERR=1, S_PRDATA=0; M_PSEL=0 next cycle; the next request is arbitrated normally.
- Reset mid-ACCESS: PRESET asserted for 2 cycles during a wait state -> all outputs 0 after the edge; after release, master 0 wins first despite both requesting.
